// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// PC step and the request-issuing state decode.
package imem_fetch_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned PC_INC    = 4;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_FETCH   = 2'd1,
        FS_DRAIN   = 2'd2,
        FS_DISCARD = 2'd3
    } fetch_state_t;

    // Both FETCH and DISCARD keep a request on the bus until it is acknowledged.
    function automatic logic fs_issues_req(input fetch_state_t s);
        return (s == FS_FETCH) || (s == FS_DISCARD);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_skid_buf.sv
// One-entry {instr, pc+4} holding buffer that catches memory data arriving
// while decode is stalled and the output register is still occupied.
module fetch_skid_buf
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_instr,
    input  logic [WIDTH-1:0] i_pc,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc
);

    logic             r_valid;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc;

    // Clear wins over load: a redirect must never let wrong-path data survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the req/ack handshake to instruction
// memory, applies decode redirects and presents {instr, pc+4} to IF/ID.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_decode,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] instr_fetch,
    output logic [WIDTH-1:0] pc_fetch,
    output logic [WIDTH-1:0] pc_current
);

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(PC_INC - 1));

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_req_addr;
    logic             r_fetch_valid;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_pc_fetch;

    logic             w_consume;
    logic             w_loadable;
    logic             w_ack_fetch;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_instr;
    logic [WIDTH-1:0] w_skid_pc;
    logic [WIDTH-1:0] w_req_next;
    logic [WIDTH-1:0] w_redir_pc;

    assign w_consume   = r_fetch_valid & ~stall_decode;
    assign w_loadable  = ~r_fetch_valid | ~stall_decode;
    assign w_ack_fetch = (r_state == FS_FETCH) & mem_ack;
    assign w_req_next  = r_req_addr + WIDTH'(PC_INC);
    assign w_redir_pc  = redirect_pc & ALIGN_MASK;

    // Data only goes to the skid when the output register is held by a stall.
    assign w_skid_load  = w_ack_fetch & ~redirect_valid & ~w_loadable;
    assign w_skid_clear = redirect_valid | ((r_state == FS_DRAIN) & w_consume);

    fetch_skid_buf #(
        .WIDTH   (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_instr (mem_rdata),
        .i_pc    (w_req_next),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= FS_IDLE;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_instr       <= '0;
            r_pc_fetch    <= '0;
        end else if (redirect_valid) begin
            // The bus request is never retracted; only its data is disowned.
            r_fetch_valid <= 1'b0;
            r_pc          <= w_redir_pc;
            unique case (r_state)
                FS_FETCH: begin
                    if (mem_ack) begin
                        r_req_addr <= w_redir_pc;
                    end else begin
                        r_state <= FS_DISCARD;
                    end
                end
                FS_DISCARD: begin
                    if (mem_ack) begin
                        r_state    <= FS_FETCH;
                        r_req_addr <= w_redir_pc;
                    end
                end
                default: begin
                    r_state    <= FS_FETCH;
                    r_req_addr <= w_redir_pc;
                end
            endcase
        end else begin
            if (w_consume) begin
                r_fetch_valid <= 1'b0;
            end
            unique case (r_state)
                FS_IDLE: begin
                    r_state    <= FS_FETCH;
                    r_req_addr <= r_pc;
                end
                FS_FETCH: begin
                    if (mem_ack) begin
                        r_pc <= w_req_next;
                        if (w_loadable) begin
                            r_fetch_valid <= 1'b1;
                            r_instr       <= mem_rdata;
                            r_pc_fetch    <= w_req_next;
                            r_req_addr    <= w_req_next;
                        end else begin
                            r_state <= FS_DRAIN;
                        end
                    end
                end
                FS_DRAIN: begin
                    if (w_consume & w_skid_valid) begin
                        r_fetch_valid <= 1'b1;
                        r_instr       <= w_skid_instr;
                        r_pc_fetch    <= w_skid_pc;
                        r_state       <= FS_FETCH;
                        r_req_addr    <= r_pc;
                    end
                end
                FS_DISCARD: begin
                    if (mem_ack) begin
                        r_state    <= FS_FETCH;
                        r_req_addr <= r_pc;
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

    assign mem_req     = fs_issues_req(r_state);
    assign mem_addr    = r_req_addr;
    assign fetch_valid = r_fetch_valid;
    assign instr_fetch = r_instr;
    assign pc_fetch    = r_pc_fetch;
    assign pc_current  = r_pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a wait-state memory responder and an
// in-order instruction-stream model checked every cycle.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_decode = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        fetch_valid;
    logic [31:0] instr_fetch;
    logic [31:0] pc_fetch;
    logic [31:0] pc_current;

    int n_vec = 0;
    int n_err = 0;
    int wait_cycles = 0;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_decode   (stall_decode),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .fetch_valid    (fetch_valid),
        .instr_fetch    (instr_fetch),
        .pc_fetch       (pc_fetch),
        .pc_current     (pc_current)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect_pulse(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_req(input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (mem_req && !mem_ack && mem_addr == a) found = 1'b1;
            else tick();
        end
        chk("wait_req_found", 32'(found), 32'd1);
    endtask

    // Memory responder: acks once a request has been held for wait_cycles cycles.
    logic prev_req_s = 1'b0;
    logic prev_ack_s = 1'b0;
    int   age = 0;
    always @(negedge clk) begin
        prev_req_s <= mem_req;
        prev_ack_s <= mem_ack;
    end
    always @(posedge clk) begin
        #1;
        if (!rst || !(prev_req_s && !prev_ack_s)) age = 0;
        else age = age + 1;
        mem_ack   = rst && mem_req && (age >= wait_cycles);
        mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hBAD0_BAD0;
    end

    // Stream model: decode must see consecutive addresses from the last
    // redirect (or reset), each exactly once, with handshake stability.
    logic [31:0] exp_pc = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    logic        prev_redir = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            exp_pc     = 32'h0;
            prev_hold  = 1'b0;
            prev_redir = 1'b0;
            chk("rst_quiet", {30'd0, mem_req, fetch_valid}, 32'd0);
        end else begin
            if (prev_hold) begin
                chk("hs_req_held", 32'(mem_req), 32'd1);
                chk("hs_addr_held", mem_addr, prev_addr);
            end
            if (prev_redir) chk("redir_flush", 32'(fetch_valid), 32'd0);
            if (fetch_valid) begin
                chk("seq_pc_fetch", pc_fetch, exp_pc + 32'd4);
                chk("seq_instr", instr_fetch, mem_word(exp_pc));
            end
            if (redirect_valid) begin
                $display("redirect to %08h", redirect_pc);
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (fetch_valid && !stall_decode) begin
                $display("consume pc=%08h instr=%08h", exp_pc, instr_fetch);
                exp_pc = exp_pc + 32'd4;
            end
            prev_hold  = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_redir = redirect_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and startup with zero-wait memory.
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", instr_fetch, 32'h0);
        chk("rst_pc_fetch", pc_fetch, 32'h0);
        chk("rst_pc_current", pc_current, 32'h0);
        rst = 1'b1;
        tick();
        chk("start_req", 32'(mem_req), 32'd1);
        chk("start_addr0", mem_addr, 32'h0);
        chk("start_fv_low", 32'(fetch_valid), 32'd0);
        tick();
        chk("start_addr4", mem_addr, 32'h4);
        chk("start_fv", 32'(fetch_valid), 32'd1);
        chk("start_pc_fetch", pc_fetch, 32'h4);
        chk("start_instr", instr_fetch, mem_word(32'h0));
        tick();
        chk("start_addr8", mem_addr, 32'h8);
        chk("start_pc_fetch2", pc_fetch, 32'h8);

        // Three wait states on a request to 0x10.
        wait_cycles = 3;
        redirect_pulse(32'h10);
        for (int k = 0; k < 3; k++) begin
            chk("ws_req", 32'(mem_req), 32'd1);
            chk("ws_addr", mem_addr, 32'h10);
            chk("ws_fv_low", 32'(fetch_valid), 32'd0);
            tick();
        end
        chk("ws_ack", 32'(mem_ack), 32'd1);
        tick();
        chk("ws_fv", 32'(fetch_valid), 32'd1);
        chk("ws_instr", instr_fetch, mem_word(32'h10));
        chk("ws_pc_fetch", pc_fetch, 32'h14);
        chk("ws_next_addr", mem_addr, 32'h14);

        // Four-cycle stall; the 0x14 ack lands in the skid.
        stall_decode = 1'b1;
        wait_cycles  = 1;
        tick();
        chk("stall_ack", 32'(mem_ack), 32'd1);
        chk("stall_hold_out", pc_fetch, 32'h14);
        tick();
        chk("stall_req_low1", 32'(mem_req), 32'd0);
        chk("stall_fv", 32'(fetch_valid), 32'd1);
        tick();
        chk("stall_req_low2", 32'(mem_req), 32'd0);
        tick();
        stall_decode = 1'b0;
        chk("stall_req_low3", 32'(mem_req), 32'd0);
        tick();
        chk("skid_fv", 32'(fetch_valid), 32'd1);
        chk("skid_instr", instr_fetch, mem_word(32'h14));
        chk("skid_pc_fetch", pc_fetch, 32'h18);
        chk("skid_resume_req", 32'(mem_req), 32'd1);
        chk("skid_resume_addr", mem_addr, 32'h18);
        for (int k = 0; k < 4; k++) tick();

        // Redirect to 0x200 while the request to 0x40 is outstanding.
        wait_cycles = 3;
        redirect_pulse(32'h40);
        wait_req(32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("disc_req", 32'(mem_req), 32'd1);
        chk("disc_addr_held", mem_addr, 32'h40);
        chk("disc_pc_current", pc_current, 32'h200);
        tick(); tick();
        chk("disc_old_ack", 32'(mem_ack), 32'd1);
        chk("disc_old_addr", mem_addr, 32'h40);
        tick();
        chk("disc_new_addr", mem_addr, 32'h200);
        chk("disc_new_req", 32'(mem_req), 32'd1);
        chk("disc_fv_low", 32'(fetch_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("disc_wait_fv_low", 32'(fetch_valid), 32'd0);
        end
        tick();
        chk("disc_fv", 32'(fetch_valid), 32'd1);
        chk("disc_pc_fetch", pc_fetch, 32'h204);
        chk("disc_instr", instr_fetch, mem_word(32'h200));

        // Redirect, ack and stall together with a full output register.
        wait_cycles = 0;
        tick(); tick();
        chk("tri_pre_ack", 32'(mem_ack), 32'd1);
        chk("tri_pre_fv", 32'(fetch_valid), 32'd1);
        stall_decode   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        stall_decode   = 1'b0;
        chk("tri_fv_low", 32'(fetch_valid), 32'd0);
        chk("tri_addr", mem_addr, 32'h200);
        chk("tri_pc_current", pc_current, 32'h200);
        tick();
        chk("tri_fv", 32'(fetch_valid), 32'd1);
        chk("tri_pc_fetch", pc_fetch, 32'h204);

        // A redirect while draining must flush the skid.
        stall_decode = 1'b1;
        tick();
        chk("flush_drain_req", 32'(mem_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        stall_decode   = 1'b0;
        chk("flush_fv_low", 32'(fetch_valid), 32'd0);
        chk("flush_addr", mem_addr, 32'h300);
        tick();
        chk("flush_pc_fetch", pc_fetch, 32'h304);
        chk("flush_instr", instr_fetch, mem_word(32'h300));

        // PC wrap at the top of the address space.
        redirect_pulse(32'hFFFF_FFFC);
        chk("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", mem_addr, 32'h0);
        chk("wrap_pc_fetch", pc_fetch, 32'h0);
        chk("wrap_instr", instr_fetch, mem_word(32'hFFFF_FFFC));
        chk("wrap_pc_current", pc_current, 32'h0);

        // Asynchronous reset in the middle of a wait state.
        wait_cycles = 3;
        redirect_pulse(32'h80);
        wait_req(32'h80);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_fv", 32'(fetch_valid), 32'd0);
        chk("mid_rst_instr", instr_fetch, 32'h0);
        chk("mid_rst_pc_fetch", pc_fetch, 32'h0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_pc_current", pc_current, 32'h0);
        wait_cycles = 0;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("restart_req", 32'(mem_req), 32'd1);
        chk("restart_addr", mem_addr, 32'h0);
        tick();
        chk("restart_fv", 32'(fetch_valid), 32'd1);
        chk("restart_pc_fetch", pc_fetch, 32'h4);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
